// File: rtl/shot_hit_detector_pkg.sv
// Purpose : shared constants, types and FSM encoding for the shot hit detector.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package shot_hit_detector_pkg;

  // Scan geometry and screen size
  localparam int NUM_SLOTS_DEF = 8;
  localparam int SLOT_AW       = $clog2(NUM_SLOTS_DEF);
  localparam int COORD_W       = 10;
  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;

  // Width used by the box compare: one sign bit over the coordinate width
  localparam int BOX_W = COORD_W + 1;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W-1:0] scoord_t;
  typedef logic [SLOT_AW-1:0]        slot_addr_t;

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_KILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    CHECK = S_CHECK,
    KILL  = S_KILL
  } state_t;

endpackage

// File: rtl/shot_hit_detector_if.sv
// Purpose : shot-table read port plus kill handshake between table and detector.
// Latency : read data is valid one cycle after slot_addr.
// Backpr. : kill_req is held until the table answers with kill_ack.
// Signals : slot_addr/slot_valid/slot_x/slot_y (read port), kill_req/kill_addr/kill_ack.
interface shot_hit_detector_if;
  import shot_hit_detector_pkg::*;

  slot_addr_t slot_addr;
  logic       slot_valid;
  coord_t     slot_x;
  scoord_t    slot_y;
  logic       kill_req;
  slot_addr_t kill_addr;
  logic       kill_ack;

  // Detector side
  modport master (
    output slot_addr, kill_req, kill_addr,
    input  slot_valid, slot_x, slot_y, kill_ack
  );

  // Shot table side
  modport slave (
    input  slot_addr, kill_req, kill_addr,
    output slot_valid, slot_x, slot_y, kill_ack
  );

endinterface

// File: rtl/shot_hit_detector_box.sv
// Purpose : combinational axis-aligned box overlap test on signed coordinates.
// Latency : 0 cycles (pure combinational).
// Backpr. : none.
// Ports   : a_* / b_* box origin and size (W-bit signed), overlap out.
module box_overlap #(
  parameter int W = 11
) (
  input  logic signed [W-1:0] a_x,
  input  logic signed [W-1:0] a_y,
  input  logic signed [W-1:0] a_w,
  input  logic signed [W-1:0] a_h,
  input  logic signed [W-1:0] b_x,
  input  logic signed [W-1:0] b_y,
  input  logic signed [W-1:0] b_w,
  input  logic signed [W-1:0] b_h,
  output logic                overlap
);

  // One extra bit so origin+size can never wrap, whatever the inputs.
  localparam int E = W + 1;

  logic signed [E-1:0] ax, ay, aw, ah, bx, by, bw, bh;

  assign ax = E'(a_x);
  assign ay = E'(a_y);
  assign aw = E'(a_w);
  assign ah = E'(a_h);
  assign bx = E'(b_x);
  assign by = E'(b_y);
  assign bw = E'(b_w);
  assign bh = E'(b_h);

  assign overlap = (ax + aw > bx) && (ax < bx + bw) &&
                   (ay + ah > by) && (ay < by + bh);

endmodule

// File: rtl/shot_hit_detector.sv
// Purpose : per-frame scan of all shot slots against the duck box; kills the first hit.
// Latency : 2 cycles per slot (addr, then data); a clean scan takes 2*NUM_SLOTS cycles.
// Backpr. : stalls in KILL until the shot table acks; frame_tick while busy sets overrun.
// Ports   : clk/reset, frame_tick, duck_respawn, duck_x/y, tbl (shot table port),
//           hit, score, duck_alive, scan_busy, overrun.
module shot_hit_detector
  import shot_hit_detector_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,  // must not exceed 2**SLOT_AW
  parameter int DUCK_W    = 32,
  parameter int DUCK_H    = 24,
  parameter int SHOT_W    = 2,
  parameter int SHOT_H    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  duck_respawn,
  input  coord_t                duck_x,
  input  coord_t                duck_y,
  shot_hit_detector_if.master   tbl,
  output logic                  hit,
  output logic [7:0]            score,
  output logic                  duck_alive,
  output logic                  scan_busy,
  output logic                  overrun
);

  localparam slot_addr_t LAST_SLOT = slot_addr_t'(NUM_SLOTS - 1);

  state_t     state_q,     state_d;
  slot_addr_t slot_addr_q, slot_addr_d;
  slot_addr_t kill_addr_q, kill_addr_d;
  logic       hit_q,       hit_d;
  logic [7:0] score_q,     score_d;
  logic       alive_q,     alive_d;
  logic       overrun_q,   overrun_d;

  // Hit test: shot box vs duck box. Coordinates are widened to BOX_W signed;
  // x values are unsigned so they get a zero sign bit, slot_y is sign-extended.
  logic overlap;
  logic hit_now;

  box_overlap #(.W(BOX_W)) u_box (
    .a_x     ({1'b0, tbl.slot_x}),
    .a_y     (BOX_W'(tbl.slot_y)),
    .a_w     (BOX_W'(SHOT_W)),
    .a_h     (BOX_W'(SHOT_H)),
    .b_x     ({1'b0, duck_x}),
    .b_y     ({1'b0, duck_y}),
    .b_w     (BOX_W'(DUCK_W)),
    .b_h     (BOX_W'(DUCK_H)),
    .overlap (overlap)
  );

  // Shots above the top of the screen (negative y) are never hittable.
  assign hit_now = tbl.slot_valid && !tbl.slot_y[COORD_W-1] && overlap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      slot_addr_q <= '0;
      kill_addr_q <= '0;
      hit_q       <= 1'b0;
      score_q     <= 8'd0;
      alive_q     <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_addr_q <= slot_addr_d;
      kill_addr_q <= kill_addr_d;
      hit_q       <= hit_d;
      score_q     <= score_d;
      alive_q     <= alive_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_addr_d = slot_addr_q;
    kill_addr_d = kill_addr_q;
    hit_d       = 1'b0;
    score_d     = score_q;
    alive_d     = alive_q;
    overrun_d   = overrun_q;

    if (frame_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A dead duck cannot be hit, so the scan is skipped altogether.
        if (frame_tick && alive_q) begin
          state_d     = ISSUE;
          slot_addr_d = '0;
        end
      end
      ISSUE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (hit_now) begin
          state_d     = KILL;
          kill_addr_d = slot_addr_q;
        end else if (slot_addr_q == LAST_SLOT) begin
          state_d = IDLE;
        end else begin
          slot_addr_d = slot_addr_q + slot_addr_t'(1);
          state_d     = ISSUE;
        end
      end
      KILL: begin
        // The hit only counts once the table confirms the shot is gone.
        if (tbl.kill_ack) begin
          hit_d   = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          alive_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Respawn overrides the death caused by a simultaneous kill ack.
    if (duck_respawn) begin
      alive_d = 1'b1;
    end
  end

  assign tbl.slot_addr = slot_addr_q;
  assign tbl.kill_req  = (state_q == KILL);
  assign tbl.kill_addr = kill_addr_q;
  assign hit           = hit_q;
  assign score         = score_q;
  assign duck_alive    = alive_q;
  assign scan_busy     = (state_q != IDLE);
  assign overrun       = overrun_q;

endmodule
